gray_counter: RTL and testbench
===============================

# gray_counter

Parametrised up/down counter that keeps a binary count and a registered, glitch-free Gray-coded copy of it. It can be reloaded from a Gray-coded value. It generalises the team's 4-bit combinational binary-to-Gray converter to N bits and adds state, direction control, load and a wrap indication. It sits wherever a Gray pointer or position code is needed, such as async FIFO pointers and encoder emulation, and drives its Gray bus straight from flops.

## Interface
- WIDTH, default 4, counter width in bits (legal range 2..32)
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  reset, synchronous and active-high
- en  input  1  advance the count by one step this cycle
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1
- load  input  1  load the count from load_gray
- load_gray  input  WIDTH  Gray-coded load value
- count_bin  output  WIDTH  current count, binary
- count_gray  output  WIDTH  current count, Gray; registered, never combinational from inputs
- wrap  output  1  one-cycle pulse, registered; see Operation

## Operation
- State is bin_q (WIDTH bits). gray_q = b2g(next bin) is registered in the same cycle, so gray_q always equals b2g(bin_q).
- Bit 0 is the LSB. Conversions:
  - b2g: g[i] = b[i] ^ b[i+1], with g[MSB] = b[MSB].
  - g2b: prefix XOR from MSB, b[i] = ^g[MSB:i].
- Priority per cycle: rst > load > en > hold.
  - rst: bin_q=0, gray_q=0, wrap=0.
  - load: bin_q = g2b(load_gray), gray_q = load_gray, wrap=0. en is ignored that cycle.
  - en & up: bin_q = bin_q+1, modulo 2^WIDTH.
  - en & !up: bin_q = bin_q-1, modulo 2^WIDTH.
  - otherwise: hold. wrap=0.
- wrap=1 for exactly one cycle after a step that crosses an end of the range:
  - counting up from all-ones to 0;
  - counting down from 0 to all-ones.
- Any legal step changes exactly one bit of count_gray. Load may change several.
- No state machine beyond the counter. No illegal states exist.

## Timing
- All outputs are registered. Latency from en/load/rst to outputs is 1 clock.
- Reset values: count_bin=0, count_gray=0, wrap=0.
- rst asserted mid-count wins over load and en in the same cycle. Counting resumes from 0 the cycle after rst deasserts.
- load with en=1 in the same cycle: load wins, with no step applied.
- Back-to-back en: one step per cycle, with no bubbles.
- up may change every cycle and takes effect on the next step.

## Configuration
- GRAY_CNT_SAT_EN
  - Defined: saturating mode.
    - An up-step at all-ones holds all-ones; a down-step at 0 holds 0.
    - wrap is instead a one-cycle pulse on each attempted step that was blocked by saturation.
    - count_gray still never changes by more than one bit per cycle.
  - Undefined: modulo wrap-around as described in Operation.
- Load, reset and priority rules are identical in both modes.

## Structure
- Shared package gray_pkg:
  - constant GRAY_MAX_WIDTH = 32;
  - functions bin2gray(b) and gray2bin(g), parametrised by width. The team's existing converters move onto these.
- One natural sub-module, gray2bin_n (WIDTH parameter). It is the combinational prefix-XOR decoder on the load path and is reused by async FIFO read-side pointer sync.
- bin2gray stays inline, since it is one XOR level.
- Top: bin_q and gray_q registers, next-state mux, wrap/saturation detect.

## Test plan
WIDTH=4 unless stated.
- Reset, then 16 cycles of en=1, up=1: count_gray goes 0000,0001,0011,0010,0110,…,1000, then 0000. wrap=1 only in the cycle count returns to 0. Every transition has Hamming distance 1.
- load=1, load_gray=1000 → next cycle count_bin=1111, count_gray=1000, wrap=0. Then en=1, up=0 → count_bin=1110, count_gray=1001.
- From count 0, en=1, up=0 → count_bin=1111, wrap=1.
  - With GRAY_CNT_SAT_EN: count_bin stays 0000 and wrap pulses once.
- Count to 5 (count_gray=0111), then rst=1, load=1, en=1 in the same cycle → all outputs 0 next cycle. load_gray is ignored.
- Same-cycle load=1 with load_gray=0110 and en=1, up=1 → count_bin=0100, not 0101.
- WIDTH=8 random en/up/load for 10k cycles against a reference model:
  - count_gray == bin2gray(count_bin) every cycle;
  - Gray changes by exactly one bit on every non-load step.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray-code constants and width-agnostic converters for counters and pointer sync.
package gray_pkg;

  localparam int GRAY_MAX_WIDTH = 32;

  typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;

  // Callers zero-extend narrower words; zero upper bits leave the low bits exact.
  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b = g;
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = g[i] ^ b[i+1];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_n.sv
// Combinational N-bit Gray-to-binary decoder (prefix XOR from the MSB down).
module gray2bin_n #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each bit is an independent reduction, so there is no ripple chain between bits.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign bin[gi] = ^gray[WIDTH-1:gi];
    end
  endgenerate

endmodule

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray copy, Gray load and wrap pulse.
// Build with GRAY_CNT_SAT_EN defined for saturating instead of modulo counting.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] count_bin,
  output logic [WIDTH-1:0] count_gray,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] bin_reg, bin_next;
  logic [WIDTH-1:0] gray_reg, gray_next;
  logic             wrap_reg, wrap_next;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] step_bin;
  logic             at_end;

  gray2bin_n #(.WIDTH(WIDTH)) u_load_dec (
    .gray (load_gray),
    .bin  (load_bin)
  );

  // at_end: the requested step would leave the range in the current direction.
  assign at_end   = up ? (bin_reg == ALL_ONES) : (bin_reg == '0);
  assign step_bin = up ? (bin_reg + WIDTH'(1)) : (bin_reg - WIDTH'(1));

  always_comb begin
    bin_next  = bin_reg;
    gray_next = gray_reg;
    wrap_next = 1'b0;
    if (load) begin
      bin_next  = load_bin;
      gray_next = load_gray;
    end else if (en) begin
`ifdef GRAY_CNT_SAT_EN
      if (at_end) begin
        wrap_next = 1'b1;
      end else begin
        bin_next = step_bin;
      end
`else
      bin_next  = step_bin;
      wrap_next = at_end;
`endif
      // Encoding the next binary value keeps the Gray bus a pure flop output.
      gray_next = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(bin_next)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_reg  <= '0;
      gray_reg <= '0;
      wrap_reg <= 1'b0;
    end else begin
      bin_reg  <= bin_next;
      gray_reg <= gray_next;
      wrap_reg <= wrap_next;
    end
  end

  assign count_bin  = bin_reg;
  assign count_gray = gray_reg;
  assign wrap       = wrap_reg;

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench: a 4-bit instance for directed cases, an 8-bit one for random traffic.
module tb_gray_counter;

  typedef struct {
    int          sel;
    string       name;
    logic [31:0] bin;
    logic [31:0] gray;
    logic        wrap;
    bit          hd_chk;
  } exp_t;

  logic       clk;
  logic       rst4, en4, up4, load4;
  logic [3:0] lg4, cb4, cg4;
  logic       w4;
  logic       rst8, en8, up8, load8;
  logic [7:0] lg8, cb8, cg8;
  logic       w8;

  exp_t        sb[$];
  int unsigned mbin[2];
  int          wid[2];
  logic [31:0] last_gray[2];
  int          n_checks;
  int          n_fail;

  gray_counter #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .en(en4), .up(up4), .load(load4),
    .load_gray(lg4), .count_bin(cb4), .count_gray(cg4), .wrap(w4)
  );

  gray_counter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .en(en8), .up(up8), .load(load8),
    .load_gray(lg8), .count_bin(cb8), .count_gray(cg8), .wrap(w8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned to_gray(input int unsigned b);
    return b ^ (b >> 1);
  endfunction

  function automatic int unsigned from_gray(input int unsigned g);
    int unsigned b;
    b = 0;
    for (int k = 0; k < 32; k++) b = b ^ (g >> k);
    return b;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One transaction: apply inputs to one instance and queue the reference result.
  task automatic drive(input int sel, input bit r, input bit l, input bit e, input bit u,
                       input int unsigned lg, input string name);
    exp_t        x;
    int          t;
    int unsigned maxv;
    bit          w;
    bit          moved;
    w = 1'b0;
    moved = 1'b0;
    @(negedge clk);
    rst4 = 1'b0; en4 = 1'b0; up4 = 1'b0; load4 = 1'b0; lg4 = '0;
    rst8 = 1'b0; en8 = 1'b0; up8 = 1'b0; load8 = 1'b0; lg8 = '0;
    if (sel == 0) begin
      rst4 = r; load4 = l; en4 = e; up4 = u; lg4 = 4'(lg);
    end else begin
      rst8 = r; load8 = l; en8 = e; up8 = u; lg8 = 8'(lg);
    end
    maxv = (32'd1 << wid[sel]) - 1;
    if (r) begin
      mbin[sel] = 0;
    end else if (l) begin
      mbin[sel] = from_gray(lg & maxv);
    end else if (e) begin
      t = int'(mbin[sel]) + (u ? 1 : -1);
      if (t < 0 || t > int'(maxv)) begin
        w = 1'b1;
`ifdef GRAY_CNT_SAT_EN
        t = int'(mbin[sel]);
`else
        t = (t < 0) ? t + int'(maxv) + 1 : t - int'(maxv) - 1;
`endif
      end
      moved = (t != int'(mbin[sel]));
      mbin[sel] = int'(unsigned'(t));
    end
    x.sel    = sel;
    x.name   = name;
    x.bin    = mbin[sel];
    x.gray   = to_gray(mbin[sel]);
    x.wrap   = w;
    x.hd_chk = moved;
    sb.push_back(x);
  endtask

  // Monitor: every clock with a queued expectation, compare the instance's outputs.
  initial begin
    exp_t        x;
    logic [31:0] ab, ag;
    logic        aw;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        if (x.sel == 0) begin
          ab = 32'(cb4); ag = 32'(cg4); aw = w4;
        end else begin
          ab = 32'(cb8); ag = 32'(cg8); aw = w8;
        end
        $display("txn %s w%0d bin=%h gray=%h wrap=%b", x.name, wid[x.sel], ab, ag, aw);
        check({x.name, " count_bin"}, ab, x.bin);
        check({x.name, " count_gray"}, ag, x.gray);
        check({x.name, " wrap"}, 32'(aw), 32'(x.wrap));
        check({x.name, " gray_vs_bin"}, ag, to_gray(ab));
        if (x.hd_chk)
          check({x.name, " gray_hamming"}, 32'($countones(ag ^ last_gray[x.sel])), 32'd1);
        last_gray[x.sel] = ag;
      end
    end
  end

  initial begin
    bit          r, l, e, u;
    int unsigned lg;
    n_checks = 0;
    n_fail   = 0;
    wid[0] = 4;
    wid[1] = 8;
    mbin[0] = 0;
    mbin[1] = 0;
    last_gray[0] = '0;
    last_gray[1] = '0;
    rst4 = 1'b1; en4 = 1'b0; up4 = 1'b0; load4 = 1'b0; lg4 = '0;
    rst8 = 1'b1; en8 = 1'b0; up8 = 1'b0; load8 = 1'b0; lg8 = '0;
    repeat (2) @(posedge clk);

    drive(0, 1, 0, 0, 0, 0, "reset");
    for (int i = 0; i < 16; i++) drive(0, 0, 0, 1, 1, 0, "count_up");
    drive(0, 0, 1, 0, 0, 'h8, "load_1000");
    drive(0, 0, 0, 1, 0, 0, "down_from_1111");
    drive(0, 0, 1, 0, 0, 'h0, "load_0000");
    drive(0, 0, 0, 1, 0, 0, "down_from_0");
    drive(0, 0, 0, 0, 0, 0, "hold");
    drive(0, 1, 0, 0, 0, 0, "reset");
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 1, 0, "count_to_5");
    drive(0, 1, 1, 1, 1, $urandom_range(1, 15), "rst_wins");
    drive(0, 0, 0, 1, 1, 0, "resume_after_rst");
    drive(0, 0, 1, 1, 1, 'h6, "load_wins");
    drive(0, 0, 0, 1, 0, 0, "up_toggle_down");
    drive(0, 0, 0, 1, 1, 0, "up_toggle_up");

    for (int i = 0; i < 10000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      l  = ($urandom_range(0, 15) == 0);
      e  = ($urandom_range(0, 3) != 0);
      u  = $urandom_range(0, 1) != 0;
      lg = $urandom_range(0, 255);
      drive(1, r, l, e, u, lg, "rand");
    end

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
